// File: rtl/cla_pkg.sv
// Shared constants and types for the registered 4-bit carry-lookahead adder.
package cla_pkg;

    localparam int CLA_WIDTH = 4;

    typedef struct packed {
        logic [CLA_WIDTH-1:0] a;
        logic [CLA_WIDTH-1:0] b;
        logic                 cin;
    } cla_ops_t;

endpackage : cla_pkg

// File: rtl/cla_4bit_core.sv
// Combinational 4-bit lookahead carry network: every carry is a flat
// sum-of-products of the propagate/generate terms, with no ripple chain.
module cla_4bit_core
    import cla_pkg::*;
(
    input  logic [CLA_WIDTH-1:0] p,
    input  logic [CLA_WIDTH-1:0] g,
    input  logic                 cin,
    output logic [CLA_WIDTH-1:0] sum,
    output logic                 cout
);

    logic [CLA_WIDTH:0] w_c;

    assign w_c[0] = cin;
    assign w_c[1] = g[0]
                  | (p[0] & w_c[0]);
    assign w_c[2] = g[1]
                  | (p[1] & g[0])
                  | (p[1] & p[0] & w_c[0]);
    assign w_c[3] = g[2]
                  | (p[2] & g[1])
                  | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & w_c[0]);
    assign w_c[4] = g[3]
                  | (p[3] & g[2])
                  | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & w_c[0]);

    assign sum  = p ^ w_c[CLA_WIDTH-1:0];
    assign cout = w_c[CLA_WIDTH];

endmodule : cla_4bit_core

// File: rtl/carry_lookahead_adder_4bit.sv
// Two-stage registered 4-bit carry-lookahead adder with a done flag that
// confirms the registered result belongs to the operands now held at stage 1.
module carry_lookahead_adder_4bit
    import cla_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CLA_WIDTH-1:0] a,
    input  logic [CLA_WIDTH-1:0] b,
    input  logic                 carry_in,
    output logic [CLA_WIDTH-1:0] partial_sum,
    output logic                 carry_out,
    output logic                 done
);

    cla_ops_t             r_s1_ops;
    logic [CLA_WIDTH-1:0] r_s1_p;
    logic [CLA_WIDTH-1:0] r_s1_g;
    logic                 r_s1_valid;

    cla_ops_t             r_s2_ops;
    logic [CLA_WIDTH-1:0] r_s2_sum;
    logic                 r_s2_cout;
    logic                 r_s2_valid;

    logic [CLA_WIDTH-1:0] w_sum;
    logic                 w_cout;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would collapse the two stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_ops   <= '0;
            r_s1_p     <= '0;
            r_s1_g     <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_ops   <= '{a: a, b: b, cin: carry_in};
            r_s1_p     <= a ^ b;
            r_s1_g     <= a & b;
            r_s1_valid <= 1'b1;
        end
    end

    cla_4bit_core u_core (
        .p    (r_s1_p),
        .g    (r_s1_g),
        .cin  (r_s1_ops.cin),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_ops   <= '0;
            r_s2_sum   <= '0;
            r_s2_cout  <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            r_s2_ops   <= r_s1_ops;
            r_s2_sum   <= w_sum;
            r_s2_cout  <= w_cout;
            r_s2_valid <= r_s1_valid;
        end
    end

    assign partial_sum = r_s2_sum;
    assign carry_out   = r_s2_cout;
    // Register-to-register compare only, so done has no path from the inputs.
    assign done        = r_s2_valid && (r_s2_ops == r_s1_ops);

endmodule : carry_lookahead_adder_4bit

// File: tb/tb_carry_lookahead_adder_4bit.sv
// Directed and sweep bench for the registered 4-bit carry-lookahead adder.
module tb_carry_lookahead_adder_4bit;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       carry_in;
    logic [3:0] partial_sum;
    logic       carry_out;
    logic       done;

    int n_vec = 0;
    int n_err = 0;

    // Operands driven at the last two falling edges (cur is newest).
    logic [8:0] cur_ops;
    logic [8:0] old_ops;

    carry_lookahead_adder_4bit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a),
        .b           (b),
        .carry_in    (carry_in),
        .partial_sum (partial_sum),
        .carry_out   (carry_out),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] ref_add(input logic [8:0] ops);
        logic [4:0] s;
        s = {1'b0, ops[8:5]} + {1'b0, ops[4:1]} + {4'b0, ops[0]};
        return s;
    endfunction

    task automatic drive(input logic [8:0] ops);
        a        = ops[8:5];
        b        = ops[4:1];
        carry_in = ops[0];
        old_ops  = cur_ops;
        cur_ops  = ops;
    endtask

    // Apply new operands at a falling edge, confirm done drops one cycle,
    // then confirm the result once stage 2 has caught up.
    task automatic directed(input string tag, input logic [8:0] ops,
                            input logic [3:0] exp_ps, input logic exp_co);
        drive(ops);
        @(negedge clk);
        check({tag, "_done_drop"}, {31'b0, done}, 32'd0);
        @(negedge clk);
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        check({tag, "_sum"},  {28'b0, partial_sum}, {28'b0, exp_ps});
        check({tag, "_cout"}, {31'b0, carry_out}, {31'b0, exp_co});
    endtask

    // One cycle: check what the last edge produced, then drive the next operands.
    task automatic step(input string tag, input logic [8:0] next_ops);
        logic [4:0] exp;
        @(negedge clk);
        exp = ref_add(old_ops);
        check({tag, "_result"}, {27'b0, carry_out, partial_sum}, {27'b0, exp});
        check({tag, "_done"}, {31'b0, done}, {31'b0, (old_ops == cur_ops)});
        drive(next_ops);
    endtask

    initial begin
        cur_ops = '0;
        old_ops = '0;
        rst_n   = 1'b0;
        drive({4'b0101, 4'b0011, 1'b0});

        // Reset held with active inputs.
        @(negedge clk);
        check("rst_sum",  {28'b0, partial_sum}, 32'd0);
        check("rst_cout", {31'b0, carry_out}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_edge1_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        check("rel_edge2_done", {31'b0, done}, 32'd1);
        check("rel_edge2_sum",  {28'b0, partial_sum}, 32'h8);
        check("rel_edge2_cout", {31'b0, carry_out}, 32'd0);

        directed("all_ones",  {4'b1111, 4'b1111, 1'b1}, 4'b1111, 1'b1);
        directed("alt_bits",  {4'b1010, 4'b0101, 1'b0}, 4'b1111, 1'b0);
        directed("prop_chain", {4'b1111, 4'b0001, 1'b0}, 4'b0000, 1'b1);
        directed("cin_only",  {4'b0000, 4'b0000, 1'b1}, 4'b0001, 1'b0);

        // Asynchronous reset between clock edges.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_sum",  {28'b0, partial_sum}, 32'd0);
        check("async_rst_cout", {31'b0, carry_out}, 32'd0);
        check("async_rst_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_done", {31'b0, done}, 32'd1);
        old_ops = cur_ops;

        // Exhaustive sweep, operands held for three cycles each.
        for (int i = 0; i < 512; i++) begin
            for (int r = 0; r < 3; r++) begin
                step("sweep", i[8:0]);
            end
        end

        // Back-to-back operand changes: done must stay low throughout.
        for (int i = 0; i < 16; i++) begin
            logic [3:0] ai;
            ai = i[3:0];
            step("b2b", {ai, ~ai, ai[0]});
            if (i > 1) check("b2b_done_low", {31'b0, done}, 32'd0);
        end
        step("flush", cur_ops);
        step("flush", cur_ops);
        step("flush", cur_ops);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_carry_lookahead_adder_4bit
